// File: rtl/mod12_hour_display_pkg.sv
// Shared constants and types for the 12-hour display stage:
// seven-segment patterns, hour limit and BCD digit width.
package mod12_hour_display_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [6:0]       seg_t;

  typedef enum logic {
    DIG_ONES,
    DIG_TENS
  } digit_sel_e;

  localparam bcd_t HOUR_MAX = 4'd11;

  // Active-high {g,f,e,d,c,b,a}
  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_DASH  = 7'b1000000;

endpackage

// File: rtl/mod12_hour_display_bcd_to_7seg.sv
// Combinational BCD to seven-segment lookup with blank and dash overrides.
module bcd_to_7seg
  import mod12_hour_display_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             blank,
  input  logic             dash,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      for (int unsigned i = 0; i < 10; i++) begin
        if (digit == bcd_t'(i)) seg = SEG_DIGIT[i];
      end
    end
  end

endmodule

// File: rtl/mod12_hour_display.sv
// Converts the mod-12 counter value to a 12-hour display with AM/PM tracking,
// illegal-count flag and a two-digit multiplexed seven-segment driver.
module mod12_hour_display
  import mod12_hour_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [3:0]       hour_tens,
  output logic [3:0]       hour_ones,
  output logic             pm,
  output logic             wrap_pulse,
  output logic             err,
  output logic [6:0]       seg,
  output logic [1:0]       an
);

  localparam int unsigned SCAN_W = $clog2(REFRESH_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]  prev_cnt;
  logic              prev_valid;
  logic [SCAN_W-1:0] scan_cnt;
  digit_sel_e        sel;

  logic       cnt_legal;
  logic       is_wrap;
  bcd_t       map_tens;
  bcd_t       map_ones;
  digit_sel_e sel_next;
  logic       show_tens;
  bcd_t       mux_digit;
  logic       mux_blank;
  logic [6:0] seg_next;

  always_comb begin
    cnt_legal = (cnt_in <= CNT_W'(HOUR_MAX));
    map_tens  = '0;
    map_ones  = bcd_t'(cnt_in);
    if (cnt_in == '0) begin
      map_tens = 4'd1;
      map_ones = 4'd2;
    end else if (cnt_in >= CNT_W'(10)) begin
      map_tens = 4'd1;
      map_ones = bcd_t'(cnt_in - CNT_W'(10));
    end
  end

  // Only an unloaded 11 -> 0 step with a valid history is a real midnight/noon roll.
  assign is_wrap = prev_valid && !load &&
                   (prev_cnt == CNT_W'(HOUR_MAX)) && (cnt_in == '0);

  always_comb begin
    sel_next = sel;
    if (scan_cnt == SCAN_LAST) begin
      sel_next = (sel == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
    show_tens = (sel_next == DIG_TENS);
    mux_digit = show_tens ? hour_tens : hour_ones;
    mux_blank = show_tens && (hour_tens == '0);
  end

  bcd_to_7seg u_seg (
    .digit (mux_digit),
    .blank (mux_blank),
    .dash  (err),
    .seg   (seg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt   <= '0;
      prev_valid <= 1'b0;
      hour_tens  <= 4'd1;
      hour_ones  <= 4'd2;
      pm         <= 1'b0;
      wrap_pulse <= 1'b0;
      err        <= 1'b0;
      scan_cnt   <= '0;
      sel        <= DIG_ONES;
      an         <= 2'b01;
      seg        <= SEG_DIGIT[2];
    end else begin
      prev_cnt   <= cnt_in;
      prev_valid <= 1'b1;
      err        <= !cnt_legal;
      if (cnt_legal) begin
        hour_tens <= map_tens;
        hour_ones <= map_ones;
      end
      wrap_pulse <= is_wrap;
      if (is_wrap) pm <= !pm;

      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      sel      <= sel_next;
      an       <= (sel_next == DIG_TENS) ? 2'b10 : 2'b01;
      seg      <= seg_next;
    end
  end

endmodule

// File: tb/tb_mod12_hour_display.sv
// Directed bench for mod12_hour_display: vector table for decode/wrap,
// hand sequences for scan timing, error dash and reset mid-operation.
module tb_mod12_hour_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] cnt_in;
  logic [3:0] hour_tens;
  logic [3:0] hour_ones;
  logic       pm;
  logic       wrap_pulse;
  logic       err;
  logic [6:0] seg;
  logic [1:0] an;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod12_hour_display #(.REFRESH_DIV(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .cnt_in     (cnt_in),
    .hour_tens  (hour_tens),
    .hour_ones  (hour_ones),
    .pm         (pm),
    .wrap_pulse (wrap_pulse),
    .err        (err),
    .seg        (seg),
    .an         (an)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] cnt;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       pm;
    logic       wrap;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic [3:0] c,
                     input logic [3:0] t, input logic [3:0] o,
                     input logic p, input logic w, input logic e);
    vec_t v;
    v.rst = r; v.load = l; v.cnt = c; v.tens = t; v.ones = o;
    v.pm = p; v.wrap = w; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] c);
    @(negedge clk);
    rst = r; load = l; cnt_in = c;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] S_BLANK = 7'b0000000;
  localparam logic [6:0] S_DASH  = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b0000110;
  localparam logic [6:0] S_0     = 7'b0111111;
  localparam logic [6:0] S_2     = 7'b1011011;
  localparam logic [6:0] S_3     = 7'b1001111;
  localparam logic [6:0] S_5     = 7'b1101101;

  initial begin
    logic [6:0] exp_ones_seg;
    logic [6:0] exp_tens_seg;
    logic [1:0] exp_an;

    rst = 1'b1; load = 1'b0; cnt_in = 4'd0;

    //   rst load cnt  tens ones pm wrap err
    add(1, 0, 4'd0,  4'd1, 4'd2, 0, 0, 0);
    add(0, 0, 4'd0,  4'd1, 4'd2, 0, 0, 0);
    add(0, 0, 4'd0,  4'd1, 4'd2, 0, 0, 0);
    add(0, 0, 4'd1,  4'd0, 4'd1, 0, 0, 0);
    add(0, 0, 4'd2,  4'd0, 4'd2, 0, 0, 0);
    add(0, 0, 4'd3,  4'd0, 4'd3, 0, 0, 0);
    add(0, 0, 4'd4,  4'd0, 4'd4, 0, 0, 0);
    add(0, 0, 4'd5,  4'd0, 4'd5, 0, 0, 0);
    add(0, 0, 4'd6,  4'd0, 4'd6, 0, 0, 0);
    add(0, 0, 4'd7,  4'd0, 4'd7, 0, 0, 0);
    add(0, 0, 4'd8,  4'd0, 4'd8, 0, 0, 0);
    add(0, 0, 4'd9,  4'd0, 4'd9, 0, 0, 0);
    add(0, 0, 4'd10, 4'd1, 4'd0, 0, 0, 0);
    add(0, 0, 4'd11, 4'd1, 4'd1, 0, 0, 0);
    add(0, 0, 4'd0,  4'd1, 4'd2, 1, 1, 0);
    add(0, 0, 4'd0,  4'd1, 4'd2, 1, 0, 0);
    add(0, 0, 4'd5,  4'd0, 4'd5, 1, 0, 0);
    add(0, 0, 4'd11, 4'd1, 4'd1, 1, 0, 0);
    add(0, 1, 4'd0,  4'd1, 4'd2, 1, 0, 0);
    add(0, 0, 4'd11, 4'd1, 4'd1, 1, 0, 0);
    add(0, 0, 4'd3,  4'd0, 4'd3, 1, 0, 0);
    add(0, 0, 4'd11, 4'd1, 4'd1, 1, 0, 0);
    add(0, 0, 4'd0,  4'd1, 4'd2, 0, 1, 0);
    add(0, 0, 4'd13, 4'd1, 4'd2, 0, 0, 1);
    add(0, 0, 4'd15, 4'd1, 4'd2, 0, 0, 1);
    add(0, 0, 4'd5,  4'd0, 4'd5, 0, 0, 0);
    add(0, 0, 4'd11, 4'd1, 4'd1, 0, 0, 0);
    add(0, 0, 4'd0,  4'd1, 4'd2, 1, 1, 0);
    add(0, 0, 4'd11, 4'd1, 4'd1, 1, 0, 0);
    add(1, 0, 4'd0,  4'd1, 4'd2, 0, 0, 0);
    add(0, 0, 4'd0,  4'd1, 4'd2, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].cnt);
      chk($sformatf("vec%0d tens", i), {4'd0, hour_tens}, {4'd0, vecs[i].tens});
      chk($sformatf("vec%0d ones", i), {4'd0, hour_ones}, {4'd0, vecs[i].ones});
      chk($sformatf("vec%0d pm", i),   {7'd0, pm},         {7'd0, vecs[i].pm});
      chk($sformatf("vec%0d wrap", i), {7'd0, wrap_pulse}, {7'd0, vecs[i].wrap});
      chk($sformatf("vec%0d err", i),  {7'd0, err},        {7'd0, vecs[i].err});
    end

    // Scan timing: reset edge is E0, then edges E1..E40 with cnt changes.
    drive(1'b1, 1'b0, 4'd3);
    chk("scan reset an",  {6'd0, an},  {6'd0, 2'b01});
    chk("scan reset seg", {1'b0, seg}, {1'b0, S_2});
    for (int k = 1; k <= 40; k++) begin
      logic [3:0] c;
      c = (k >= 36) ? 4'd5 : (k >= 27) ? 4'd13 : (k >= 18) ? 4'd10 : 4'd3;
      drive(1'b0, 1'b0, c);
      if (k >= 37) begin
        exp_ones_seg = S_5;  exp_tens_seg = S_BLANK;
      end else if (k >= 28) begin
        exp_ones_seg = S_DASH; exp_tens_seg = S_DASH;
      end else if (k >= 19) begin
        exp_ones_seg = S_0;  exp_tens_seg = S_1;
      end else begin
        exp_ones_seg = S_3;  exp_tens_seg = S_BLANK;
      end
      exp_an = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
      chk($sformatf("scan k%0d an", k), {6'd0, an}, {6'd0, exp_an});
      if (k >= 2) begin
        chk($sformatf("scan k%0d seg", k), {1'b0, seg},
            {1'b0, (exp_an == 2'b10) ? exp_tens_seg : exp_ones_seg});
      end
      if (k == 27) begin
        chk("err set", {7'd0, err}, 8'd1);
        chk("err hold tens", {4'd0, hour_tens}, 8'd1);
        chk("err hold ones", {4'd0, hour_ones}, 8'd0);
      end
      if (k == 36) begin
        chk("err clear", {7'd0, err}, 8'd0);
        chk("err recover ones", {4'd0, hour_ones}, 8'd5);
      end
    end

    // Reset while pm=1 and mid-scan; prior count 11 must not wrap after release.
    drive(1'b0, 1'b0, 4'd11);
    drive(1'b0, 1'b0, 4'd0);
    chk("pre-reset wrap", {7'd0, wrap_pulse}, 8'd1);
    chk("pre-reset pm",   {7'd0, pm},         8'd1);
    drive(1'b0, 1'b0, 4'd11);
    drive(1'b1, 1'b0, 4'd0);
    chk("midrst pm",   {7'd0, pm},         8'd0);
    chk("midrst an",   {6'd0, an},         {6'd0, 2'b01});
    chk("midrst seg",  {1'b0, seg},        {1'b0, S_2});
    chk("midrst tens", {4'd0, hour_tens},  8'd1);
    chk("midrst ones", {4'd0, hour_ones},  8'd2);
    chk("midrst wrap", {7'd0, wrap_pulse}, 8'd0);
    drive(1'b0, 1'b0, 4'd0);
    chk("post-rst wrap", {7'd0, wrap_pulse}, 8'd0);
    chk("post-rst pm",   {7'd0, pm},         8'd0);
    drive(1'b0, 1'b0, 4'd0);
    chk("post-rst hold wrap", {7'd0, wrap_pulse}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod12_hour_display.md
Name: mod12_hour_display

Overview:
- Downstream consumer of the loadable mod-12 counter's 4-bit count.
- Interprets count 0..11 as a 12-hour clock hour: count 0 shows "12", counts 1..11 show "1".."11".
- Tracks AM/PM by detecting natural wrap-around (11 -> 0). Reports illegal counts.
- Drives a 2-digit time-multiplexed seven-segment display with a programmable scan divider.

Parameters:
- REFRESH_DIV, 4, clock cycles per digit scan slot (legal range >= 2).
- CNT_W, 4, width of the incoming count; fixed at 4 for this stage.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- load  input  1  same load strobe as the upstream counter; marks non-natural count changes.
- cnt_in  input  4  upstream counter output q.
- hour_tens  output  4  registered BCD tens of displayed hour (0 or 1).
- hour_ones  output  4  registered BCD ones of displayed hour (0..9).
- pm  output  1  0 = AM, 1 = PM.
- wrap_pulse  output  1  one-cycle pulse on natural 11 -> 0 wrap.
- err  output  1  high while the sampled count is > 11.
- seg  output  7  active-high segments {g,f,e,d,c,b,a} for the currently selected digit.
- an  output  2  one-hot active-high digit enable; an[1] = tens, an[0] = ones.

Behaviour:
- Reset (rst=1 at posedge) forces:
  - hour_tens=1, hour_ones=2, pm=0, wrap_pulse=0, err=0.
  - prev_valid=0, scan counter=0, an=2'b01.
  - seg = pattern for '2' (7'b1011011).
- Reset mid-operation is identical to power-up reset. It takes priority over all other events in the same cycle.
- Sampling:
  - Each posedge registers cnt_in into prev_cnt and sets prev_valid=1.
  - Decode outputs (hour_tens, hour_ones, err) reflect the cnt_in sampled at that edge, so they are valid the cycle after cnt_in changes (1-cycle latency).
- Mapping:
  - cnt_in 0 -> 12; 1..9 -> tens=0, ones=cnt; 10 -> 1,0; 11 -> 1,1.
  - cnt_in 12..15 -> err=1; hour_tens/hour_ones hold their last legal values.
- Wrap detection:
  - wrap_pulse=1 for exactly one cycle when prev_valid=1, load=0, prev_cnt=11 and cnt_in=0. pm toggles on that same edge.
  - No wrap and no toggle in any of these cases:
    - load=1 in the cycle of the change.
    - first sample after reset (prev_valid=0).
    - a change 11 -> anything other than 0.
  - Holding cnt_in=0 across cycles yields only one pulse.
- Scan:
  - The divider counts 0..REFRESH_DIV-1. On terminal count it wraps to 0 and the digit select toggles (an alternates 01 <-> 10).
  - seg is registered and updates on the same edge as an.
  - Ones digit: standard 0..9 patterns:
    - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
    - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Tens digit: '1' pattern when hour_tens=1; blank (0000000) when hour_tens=0 (leading-zero suppression).
  - When err=1, both digits show dash (1000000).
- Simultaneous load and wrap-shaped change: load wins, no toggle.
- Changes to rst/load/cnt_in are driven on negedge by the bench, so they are stable at posedge.

Decomposition:
- Shared package holds:
  - SEG_DIGIT[0:9] segment constants, SEG_BLANK, SEG_DASH.
  - HOUR_MAX=11 constant.
  - Width of the BCD digit type (4).
- One natural sub-module: bcd_to_7seg. Combinational lookup from 4-bit BCD plus blank/dash controls to 7-bit seg, instantiated once on the muxed digit.
- Scan divider, wrap detector and mapping stay in the top module.

Test Plan:
- Reset then cnt_in=0 held -> hour_tens=1, hour_ones=2, pm=0, err=0, wrap_pulse never asserted.
- Step cnt_in 0..11 then 0, load=0 -> hours 12,1..11,12. wrap_pulse high one cycle after the 0 is sampled; pm 0 -> 1. A second full cycle returns pm to 0.
- cnt_in 11 -> 0 with load=1 on the changing cycle -> hour becomes 12, wrap_pulse=0, pm unchanged.
- cnt_in=13 -> err=1 next cycle; segments show 1000000 on both an phases; hour_tens/hour_ones keep previous values. Return to cnt_in=5 -> err=0, hour_ones=5.
- REFRESH_DIV=4, cnt_in=3 -> an toggles every 4 cycles. Ones phase seg=1001111; tens phase seg=0000000. cnt_in=10 -> tens seg=0000110, ones seg=0111111.
- Reset asserted while pm=1 and mid-scan -> next edge: pm=0, an=01, hour 12. First sample after release of 0 (prev 11 before reset) gives no wrap_pulse.
